// File: rtl/mux_pkg.sv
// Shared helpers for the mux family: channel-index width and index wrap.
package mux_pkg;

    // Width of a channel index; never narrower than one bit.
    function automatic int sel_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    // Wraps an index that may have run at most one lap past ch-1.
    // A subtract instead of a modulo keeps the logic small for odd CH.
    function automatic int idx_wrap(input int i, input int ch);
        return (i >= ch) ? i - ch : i;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
module rr_arbiter import mux_pkg::*; #(
    parameter int CH    = 4,
    parameter int SEL_W = sel_w(CH)
) (
    input  logic [CH-1:0]    req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [CH-1:0]    gnt,
    output logic [SEL_W-1:0] gnt_idx
);

    logic             found;
    logic [SEL_W-1:0] cand;

    // Scan CH positions starting at ptr; gnt_idx is valid even when en is low.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < CH; k++) begin
            cand = SEL_W'(idx_wrap(int'(ptr) + k, CH));
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Registered round-robin N-bit mux with valid/ready on every channel.
// Optional packet lock (in_last/out_last ports) enabled by RR_ARB_MUX_LOCK_EN.
module rr_arb_mux import mux_pkg::*; #(
    parameter int N     = 64,
    parameter int CH    = 4,
    parameter int SEL_W = $clog2(CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH-1:0]    in_valid,
    input  logic [CH*N-1:0]  in_data,
    output logic [CH-1:0]    in_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready
`ifdef RR_ARB_MUX_LOCK_EN
    ,
    input  logic [CH-1:0]    in_last,
    output logic             out_last
`endif
);

    logic             load;
    logic [CH-1:0]    eligible;
    logic [CH-1:0]    arb_gnt;
    logic [SEL_W-1:0] arb_idx;
    logic [N-1:0]     sel_data;

    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;
`ifdef RR_ARB_MUX_LOCK_EN
    logic             out_last_q,  out_last_d;
    logic             locked_q,    locked_d;
    logic             sel_last;
    logic [CH-1:0]    lock_mask;
`endif

    // The output register can take a new beat when empty or being drained.
    always_comb load = !out_valid_q || out_ready;

`ifdef RR_ARB_MUX_LOCK_EN
    // While locked, ptr_q still points at the locked channel, so it doubles as the mask.
    always_comb begin
        lock_mask = '0;
        for (int c = 0; c < CH; c++) begin
            lock_mask[c] = (int'(ptr_q) == c);
        end
        eligible = locked_q ? (in_valid & lock_mask) : in_valid;
    end
`else
    // Every valid channel competes on every beat.
    always_comb eligible = in_valid;
`endif

    rr_arbiter #(
        .CH    (CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (eligible),
        .ptr     (ptr_q),
        .en      (load && !reset),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign in_ready = arb_gnt;

    // Select the winner's data (and last) by index.
    always_comb begin
        sel_data = '0;
`ifdef RR_ARB_MUX_LOCK_EN
        sel_last = 1'b0;
`endif
        for (int c = 0; c < CH; c++) begin
            if (int'(arb_idx) == c) begin
                sel_data = in_data[c*N +: N];
`ifdef RR_ARB_MUX_LOCK_EN
                sel_last = in_last[c];
`endif
            end
        end
    end

    // Next-state: load on grant, drain to empty on an idle load, hold on stall.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
`ifdef RR_ARB_MUX_LOCK_EN
        out_last_d  = out_last_q;
        locked_d    = locked_q;
`endif
        if (|arb_gnt) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = arb_idx;
            ptr_d       = SEL_W'(idx_wrap(int'(arb_idx) + 1, CH));
`ifdef RR_ARB_MUX_LOCK_EN
            out_last_d  = sel_last;
            locked_d    = !sel_last;
            if (!sel_last) begin
                ptr_d = arb_idx;
            end
`endif
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; a held beat is dropped on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
            out_last_q  <= 1'b0;
            locked_q    <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
`ifdef RR_ARB_MUX_LOCK_EN
            out_last_q  <= out_last_d;
            locked_q    <= locked_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
`ifdef RR_ARB_MUX_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed steps plus random traffic against a model.
module tb_rr_arb_mux;

    localparam int CH4 = 4;
    localparam int N4  = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [CH4-1:0]  in_valid;
    logic [CH4*N4-1:0] in_data;
    logic [CH4-1:0]  in_ready;
    logic            out_valid;
    logic [N4-1:0]   out_data;
    logic [1:0]      out_sel;
    logic            out_ready;

    logic [2:0]      in_valid3;
    logic [23:0]     in_data3;
    logic [2:0]      in_ready3;
    logic            out_valid3;
    logic [7:0]      out_data3;
    logic [1:0]      out_sel3;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [CH4-1:0]  in_last;
    logic            out_last;
    logic            out_last3;
    logic            ll [CH4];
    logic            m_last;
    logic            m_locked;
`endif

    int errors = 0;
    int checks = 0;

    logic        v  [CH4];
    logic [63:0] dd [CH4];

    logic        m_valid;
    logic [63:0] m_data;
    int          m_sel;
    int          m_ptr;
    logic [3:0]  obs_ready;
    logic [3:0]  acc;

    always #5 clk = ~clk;

    rr_arb_mux #(.N(N4), .CH(CH4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
`ifdef RR_ARB_MUX_LOCK_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

    rr_arb_mux #(.N(8), .CH(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_ready (1'b1)
`ifdef RR_ARB_MUX_LOCK_EN
        ,
        .in_last   (3'b111),
        .out_last  (out_last3)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive the arrays, check in_ready, advance model and DUT, check outputs.
    task automatic cycle();
        int w;
        int c;
        logic [3:0] exp_ready;
        logic load;
        for (int i = 0; i < CH4; i++) begin
            in_valid[i]          = v[i];
            in_data[i*N4 +: N4]  = dd[i];
`ifdef RR_ARB_MUX_LOCK_EN
            in_last[i]           = ll[i];
`endif
        end
        #1;
        load = !m_valid || out_ready;
        w = -1;
        for (int k = 0; k < CH4; k++) begin
            c = (m_ptr + k) % CH4;
`ifdef RR_ARB_MUX_LOCK_EN
            if (w < 0 && v[c] && (!m_locked || c == m_ptr)) w = c;
`else
            if (w < 0 && v[c]) w = c;
`endif
        end
        exp_ready = 4'b0000;
        if (!reset && load && w >= 0) exp_ready[w] = 1'b1;
        obs_ready = in_ready;
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
`ifdef RR_ARB_MUX_LOCK_EN
            m_last = 1'b0; m_locked = 1'b0;
`endif
        end else if (load) begin
            if (w >= 0) begin
                m_valid = 1'b1; m_data = dd[w]; m_sel = w;
                m_ptr = (w + 1) % CH4;
`ifdef RR_ARB_MUX_LOCK_EN
                m_last = ll[w];
                m_locked = !ll[w];
                if (!ll[w]) m_ptr = w;
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
        acc = exp_ready;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_data", out_data, m_data);
        chk("out_sel", 64'(out_sel), 64'(m_sel));
`ifdef RR_ARB_MUX_LOCK_EN
        chk("out_last", 64'(out_last), 64'(m_last));
`endif
    endtask

    initial begin
        int seq [5];
        seq = '{0, 1, 2, 3, 0};
        reset = 1'b1; out_ready = 1'b0;
        in_valid3 = '0; in_data3 = '0;
        m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
        for (int i = 0; i < CH4; i++) begin
            v[i] = 1'b0; dd[i] = '0;
`ifdef RR_ARB_MUX_LOCK_EN
            ll[i] = 1'b1;
`endif
        end
`ifdef RR_ARB_MUX_LOCK_EN
        m_last = 1'b0; m_locked = 1'b0;
`endif
        cycle();
        cycle();
        reset = 1'b0;

        // Full contention: strict rotation, no bubbles.
        out_ready = 1'b1;
        for (int i = 0; i < CH4; i++) begin v[i] = 1'b1; dd[i] = 64'h10 + 64'(i); end
        for (int s = 0; s < 5; s++) begin
            cycle();
            chk("fc_sel", 64'(out_sel), 64'(seq[s]));
            chk("fc_data", out_data, 64'h10 + 64'(seq[s]));
            chk("fc_valid", 64'(out_valid), 64'd1);
        end

        // Back-pressure on a lone channel 2.
        for (int i = 0; i < CH4; i++) v[i] = 1'b0;
        v[2] = 1'b1; dd[2] = 64'hAB;
        cycle();
        chk("bp_load", out_data, 64'hAB);
        dd[2] = 64'hCD; out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            cycle();
            chk("bp_hold", out_data, 64'hAB);
            chk("bp_ready", 64'(obs_ready), 64'd0);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_release_ready", 64'(obs_ready), 64'b0100);
        chk("bp_release_data", out_data, 64'hCD);

        // Reset while stalled with a beat held.
        out_ready = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_sel", 64'(out_sel), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < CH4; i++) begin v[i] = 1'b1; dd[i] = 64'h10 + 64'(i); end
        cycle();
        chk("rst_ptr", 64'(out_sel), 64'd0);

        // Sparse: only channel 1, one beat per cycle.
        for (int i = 0; i < CH4; i++) v[i] = 1'b0;
        v[1] = 1'b1; dd[1] = 64'h55;
        for (int s = 0; s < 6; s++) begin
            cycle();
            chk("sp_sel", 64'(out_sel), 64'd1);
            chk("sp_valid", 64'(out_valid), 64'd1);
        end
        v[1] = 1'b0;

        // CH=3 wrap: move ptr to 2, then requests on 0 and 1.
        in_data3 = {8'h22, 8'h21, 8'h30};
        in_valid3 = 3'b010;
        #1 chk("w3_ready_a", 64'(in_ready3), 64'b010);
        cycle();
        chk("w3_sel_a", 64'(out_sel3), 64'd1);
        in_valid3 = 3'b011;
        #1 chk("w3_ready_b", 64'(in_ready3), 64'b001);
        cycle();
        chk("w3_sel_b", 64'(out_sel3), 64'd0);
        chk("w3_data_b", 64'(out_data3), 64'h30);
        #1 chk("w3_ready_c", 64'(in_ready3), 64'b010);
        cycle();
        chk("w3_sel_c", 64'(out_sel3), 64'd1);
        chk("w3_data_c", 64'(out_data3), 64'h21);
        in_valid3 = 3'b000;

`ifdef RR_ARB_MUX_LOCK_EN
        // Packet lock: 3-beat packet on ch0 with a mid-packet idle cycle.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        v[0] = 1'b1; dd[0] = 64'hA0; ll[0] = 1'b0;
        v[1] = 1'b1; dd[1] = 64'hB0; ll[1] = 1'b1;
        cycle();
        chk("lk_sel_0", 64'(out_sel), 64'd0);
        dd[0] = 64'hA1;
        cycle();
        chk("lk_sel_1", 64'(out_sel), 64'd0);
        v[0] = 1'b0;
        cycle();
        chk("lk_bubble_valid", 64'(out_valid), 64'd0);
        chk("lk_bubble_ready", 64'(obs_ready), 64'd0);
        v[0] = 1'b1; dd[0] = 64'hA2; ll[0] = 1'b1;
        cycle();
        chk("lk_sel_2", 64'(out_sel), 64'd0);
        chk("lk_last", 64'(out_last), 64'd1);
        v[0] = 1'b0;
        cycle();
        chk("lk_sel_3", 64'(out_sel), 64'd1);
        v[1] = 1'b0;
`endif

        // Random traffic obeying hold-until-accepted.
        for (int s = 0; s < 600; s++) begin
            for (int i = 0; i < CH4; i++) begin
                if (!v[i] && $urandom_range(0, 2) != 0) begin
                    v[i] = 1'b1;
                    dd[i] = {$urandom, $urandom};
`ifdef RR_ARB_MUX_LOCK_EN
                    ll[i] = 1'($urandom_range(0, 1));
`endif
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 99) == 0);
            cycle();
            for (int i = 0; i < CH4; i++) if (acc[i]) v[i] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
